// File: rtl/cnt_disp.sv
// Binary count to 4-digit BCD (serial double-dabble) with a multiplexed 7-segment scan.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module cnt_disp #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_val,
    input  logic [31:0] in_data,
    output logic        in_rdy,
    output logic [15:0] digits,
    output logic        ovf,
    output logic        valid_o,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [13:0]      bin_q, bin_d;
    logic [15:0]      bcd_q, bcd_d;
    logic [3:0]       step_q, step_d;
    logic             povf_q, povf_d;
    logic [15:0]      digits_q, digits_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      adj_s;
    logic [3:0]       nib_s;

    // Add 3 to every nibble that is 5 or more, ahead of the doubling shift.
    function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
            end else begin
                r[i*4 +: 4] = b[i*4 +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Conversion FSM: accept, 14 shift-add-3 steps, then publish the result.
    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        step_d   = step_q;
        povf_d   = povf_q;
        digits_d = digits_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;
        adj_s    = bcd_adjust(bcd_q);
        case (state_q)
            IDLE: begin
                if (in_val) begin
                    bin_d   = (in_data > 32'd9999) ? 14'd9999 : in_data[13:0];
                    povf_d  = (in_data > 32'd9999);
                    bcd_d   = 16'd0;
                    step_d  = 4'd0;
                    state_d = CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                {bcd_d, bin_d} = {adj_s, bin_q} << 1;
                step_d = step_q + 4'd1;
                if (step_q == 4'd13) begin
                    state_d = DONE;
                end else begin
                    state_d = CONV;
                end
            end
            DONE: begin
                digits_d = bcd_q;
                ovf_d    = povf_q;
                valid_d  = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Free-running scan divider; never looks at the FSM.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
        if (div_q == DIV_LAST) begin
            div_d = {DIV_W{1'b0}};
            idx_d = idx_q + 2'd1;
        end else begin
            idx_d = idx_q;
        end
    end

    // State registers for conversion, result and scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            bin_q    <= 14'd0;
            bcd_q    <= 16'd0;
            step_q   <= 4'd0;
            povf_q   <= 1'b0;
            digits_q <= 16'd0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            div_q    <= {DIV_W{1'b0}};
            idx_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            step_q   <= step_d;
            povf_q   <= povf_d;
            digits_q <= digits_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            div_q    <= div_d;
            idx_q    <= idx_d;
        end
    end

    // Digit select and segment decode straight from registered state.
    always_comb begin
        nib_s = digits_q[idx_q*4 +: 4];
        an    = 4'b0001 << idx_q;
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx_q == 2'd3 && digits_q[15:12] == 4'd0) ||
            (idx_q == 2'd2 && digits_q[15:8] == 8'd0) ||
            (idx_q == 2'd1 && digits_q[15:4] == 12'd0)) begin
            seg = 7'b0000000;
        end else begin
            seg = seg_decode(nib_s);
        end
`else
        seg = seg_decode(nib_s);
`endif
    end

    assign in_rdy  = (state_q == IDLE);
    assign digits  = digits_q;
    assign ovf     = ovf_q;
    assign valid_o = valid_q;

endmodule

// File: doc/cnt_disp.md
CNT_DISP -- requirements
Module: cnt_disp

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4, clock cycles each display digit is held (>=1).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_val  input  1  upstream count sample valid.
REQ-005 SHALL have port in_data  input  32  unsigned binary count from the upstream counter.
REQ-006 SHALL have port in_rdy  output  1  block can accept a sample this cycle.
REQ-007 SHALL have port digits  output  16  latched BCD result; [3:0] ones, [7:4] tens, [11:8] hundreds, [15:12] thousands.
REQ-008 SHALL have port ovf  output  1  latched result was saturated.
REQ-009 SHALL have port valid_o  output  1  one-cycle pulse when digits/ovf update.
REQ-010 SHALL have port an  output  4  one-hot digit select, active-high; an[i] selects digit i.
REQ-011 SHALL have port seg  output  7  active-high segments; seg[0]=a ... seg[6]=g.

Function
REQ-012 SHALL implement FSM states IDLE, CONV, DONE; in_rdy=1 only in IDLE.
REQ-013 SHALL accept a sample on a rising edge with in_val=1 and in_rdy=1, then enter CONV.
REQ-014 SHALL ignore in_val in CONV/DONE; no queuing, no side effects.
REQ-015 SHALL, on accept, load min(in_data, 9999) as a 14-bit value; load pending-ovf = (in_data > 9999).
REQ-016 SHALL, in CONV, perform exactly 14 shift-add-3 steps, one per cycle: add 3 to each BCD nibble >=5, then shift left one bit, MSB-first.
REQ-017 SHALL enter DONE on the edge completing step 14 (accept edge t0 + 14).
REQ-018 SHALL, in DONE, update digits and ovf on edge t0+15 and return to IDLE; valid_o SHALL be 1 for exactly the cycle after t0+15.
REQ-019 SHALL allow the next accept no earlier than edge t0+16 (the first IDLE cycle).
REQ-020 SHALL hold digits/ovf constant between updates; a conversion in progress SHALL NOT alter them.
REQ-021 SHALL run a free-running scan divider: digit index advances every SCAN_DIV cycles, 0->1->2->3->0.
REQ-022 SHALL drive an = one-hot(index); seg = 7-seg decode of digits nibble at index (0=7'b0111111, 1=7'b0000110, ... 9=7'b1101111).
REQ-023 SHALL drive seg=7'b0000000 for any nibble >9 (not reachable in normal operation).
REQ-024 SHALL keep scan timing independent of the FSM and of in_val.

Reset
REQ-025 SHALL, while rst=1, immediately force: state IDLE, in_rdy=1, digits=0, ovf=0, valid_o=0, scan index 0, divider 0, an=4'b0001, seg=7'b0111111.
REQ-026 SHALL abort any conversion on rst. No valid_o pulse SHALL follow the abort. digits SHALL remain 0 until a new sample is accepted after reset release.

Configuration
REQ-027 SHALL support macro LEADING_ZERO_BLANK_EN.
REQ-028 With LEADING_ZERO_BLANK_EN defined, seg SHALL be 0 for any digit above the most significant nonzero digit. Digit 0 SHALL always be shown. an SHALL still scan normally.
REQ-029 Without LEADING_ZERO_BLANK_EN, all four digits SHALL always be decoded.

Verification
REQ-030 Reset, then in_data=123 with in_val for one cycle at edge t0 -> in_rdy=0 for t0..t0+15; digits=16'h0123, ovf=0 after t0+15; valid_o high one cycle; in_rdy=1.
REQ-031 in_data=10000 -> digits=16'h9999, ovf=1. Following in_data=42 -> digits=16'h0042, ovf=0.
REQ-032 in_val=1 with in_data=777 at t0+5 during a conversion of 999 -> result 16'h0999; 777 never appears.
REQ-033 rst pulsed at t0+7 during a conversion of 500 -> all outputs at reset values immediately; no valid_o pulse; digits stay 0.
REQ-034 SCAN_DIV=4, digits=16'h0123, macro off -> an=0001 seg=1001111 for 4 cycles, then an=0010 seg=1011011, an=0100 seg=0000110, an=1000 seg=0111111, then wraps.
REQ-035 Macro on, digits=16'h0007 -> an=1000/0100/0010 give seg=0; an=0001 gives seg=0000111. digits=16'h0000 -> only digit 0 shows 0111111.
